core_top: RTL and testbench

//  Single processing core: instruction unit (decode/FSM), 32x32 register file and combinational ALU.

---
 rtl/system_widths_pkg.sv | 48 ++++
 rtl/alu.sv | 25 ++
 rtl/instruction_unit.sv | 96 +++++++++
 rtl/regfile.sv | 27 ++
 rtl/core_top.sv | 85 ++++++++
 tb/tb_core_top.sv | 193 +++++++++++++++++++
 6 files changed

// File: rtl/system_widths_pkg.sv
// rtl/system_widths_pkg.sv - shared widths, field positions, opcode/ALU enums and FSM states
package system_widths_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int IMM_W      = 13;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 23;
    localparam int RS1_LSB = 18;
    localparam int RS2_LSB = 13;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_ADDI  = 4'h8,
        OP_LOAD  = 4'h9,
        OP_STORE = 4'hA
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_NONE = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU, wrap-around arithmetic, no flags
module alu
    import system_widths_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  alu_op_e         i_alu_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_done
);
    always_comb begin
        o_result = '0;
        o_done   = 1'b1;
        case (i_alu_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_SLL: o_result = i_a << i_b[4:0];
            ALU_SRL: o_result = i_a >> i_b[4:0];
            default: o_done   = 1'b0;
        endcase
    end
endmodule

// File: rtl/instruction_unit.sv
// rtl/instruction_unit.sv - instruction capture, decode and IDLE/EXEC/MEM/DONE sequencing
module instruction_unit
    import system_widths_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_instr_valid,
    input  logic [XLEN-1:0]       i_instr,
    output logic                  o_instr_ready,
    output logic [REG_ADDR_W-1:0] o_rf_raddr_a,
    output logic [REG_ADDR_W-1:0] o_rf_raddr_b,
    input  logic [XLEN-1:0]       i_rf_rdata_b,
    output alu_op_e               o_alu_op,
    output logic [XLEN-1:0]       o_alu_b,
    input  logic [XLEN-1:0]       i_alu_result,
    input  logic                  i_alu_done,
    output logic                  o_rf_wen,
    output logic [REG_ADDR_W-1:0] o_rf_waddr,
    output logic [XLEN-1:0]       o_rf_wdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [XLEN-1:0]       o_mem_addr,
    output logic [XLEN-1:0]       o_mem_wdata,
    input  logic [XLEN-1:0]       i_mem_rdata,
    input  logic                  i_mem_ack,
    output logic                  o_illegal_op
);
    state_e          r_state, w_next_state;
    logic [XLEN-1:0] r_instr;
    logic [3:0]      w_op;
    logic            w_is_alu, w_is_mem, w_use_imm, w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && i_instr_valid) r_instr <= i_instr;
        end
    end

    assign w_op      = r_instr[OP_LSB +: 4];
    assign w_illegal = (w_op > OP_STORE);

    // LOAD/STORE reuse the ALU adder for rs1 + sext(imm)
    always_comb begin
        o_alu_op  = ALU_ADD;
        w_is_alu  = 1'b0;
        w_is_mem  = 1'b0;
        w_use_imm = 1'b0;
        case (w_op)
            OP_ADD:   begin o_alu_op = ALU_ADD; w_is_alu = 1'b1; end
            OP_SUB:   begin o_alu_op = ALU_SUB; w_is_alu = 1'b1; end
            OP_AND:   begin o_alu_op = ALU_AND; w_is_alu = 1'b1; end
            OP_OR:    begin o_alu_op = ALU_OR;  w_is_alu = 1'b1; end
            OP_XOR:   begin o_alu_op = ALU_XOR; w_is_alu = 1'b1; end
            OP_SLL:   begin o_alu_op = ALU_SLL; w_is_alu = 1'b1; end
            OP_SRL:   begin o_alu_op = ALU_SRL; w_is_alu = 1'b1; end
            OP_ADDI:  begin w_is_alu = 1'b1; w_use_imm = 1'b1; end
            OP_LOAD,
            OP_STORE: begin w_is_mem = 1'b1; w_use_imm = 1'b1; end
            default:  o_alu_op = ALU_NONE;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        o_rf_wen     = 1'b0;
        o_rf_wdata   = i_alu_result;
        case (r_state)
            S_IDLE: if (i_instr_valid) w_next_state = S_EXEC;
            S_EXEC: begin
                w_next_state = w_is_mem ? S_MEM : S_DONE;
                o_rf_wen     = w_is_alu && i_alu_done;
            end
            S_MEM: if (i_mem_ack) begin
                w_next_state = S_DONE;
                o_rf_wen     = (w_op == OP_LOAD);
                o_rf_wdata   = i_mem_rdata;
            end
            S_DONE: w_next_state = S_IDLE;
        endcase
    end

    assign o_alu_b       = w_use_imm ? sext_imm(r_instr[IMM_W-1:0]) : i_rf_rdata_b;
    assign o_rf_raddr_a  = r_instr[RS1_LSB +: REG_ADDR_W];
    assign o_rf_raddr_b  = r_instr[RS2_LSB +: REG_ADDR_W];
    assign o_rf_waddr    = r_instr[RD_LSB +: REG_ADDR_W];
    assign o_instr_ready = (r_state == S_IDLE);
    assign o_mem_req     = (r_state == S_MEM);
    assign o_mem_we      = (r_state == S_MEM) && (w_op == OP_STORE);
    assign o_mem_addr    = i_alu_result;
    assign o_mem_wdata   = i_rf_rdata_b;
    assign o_illegal_op  = (r_state == S_DONE) && w_illegal;
endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two async read ports, one sync write port, r0 hardwired to 0
module regfile
    import system_widths_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] i_raddr_a,
    input  logic [REG_ADDR_W-1:0] i_raddr_b,
    output logic [XLEN-1:0]       o_rdata_a,
    output logic [XLEN-1:0]       o_rdata_b,
    input  logic                  i_wen,
    input  logic [REG_ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]       i_wdata
);
    logic [XLEN-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_wen && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];
endmodule

// File: rtl/core_top.sv
// rtl/core_top.sv - single processing core: instruction unit, register file, ALU and debug taps
module core_top
    import system_widths_pkg::*;
#(
    parameter int CORE_INDEX  = 0,
    parameter int INSTR_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  instr_valid,
    input  logic [XLEN-1:0]       instr,
    output logic                  instr_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata,
    input  logic                  mem_ack,
    output logic [7:0]            mem_core_id,
    output logic                  illegal_op,
    output logic [XLEN-1:0]       dbg_alu_result,
    output logic [REG_ADDR_W-1:0] dbg_rf_raddr_a,
    output logic [REG_ADDR_W-1:0] dbg_rf_raddr_b,
    output logic [XLEN-1:0]       dbg_rf_rdata_a,
    output logic [XLEN-1:0]       dbg_rf_rdata_b,
    output logic                  dbg_rf_wen,
    output logic [REG_ADDR_W-1:0] dbg_rf_waddr,
    output logic [XLEN-1:0]       dbg_rf_wdata
);
    // The local instruction buffer is not built yet; the depth is only sanity-checked.
    if (INSTR_COUNT < 1) begin : g_bad_instr_count
        $error("INSTR_COUNT must be at least 1");
    end

    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_alu_b;
    logic            w_alu_done;

    assign mem_core_id = 8'(CORE_INDEX);

    instruction_unit u_iu (
        .clk           (clk),
        .rst_n         (resetN),
        .i_instr_valid (instr_valid),
        .i_instr       (instr),
        .o_instr_ready (instr_ready),
        .o_rf_raddr_a  (dbg_rf_raddr_a),
        .o_rf_raddr_b  (dbg_rf_raddr_b),
        .i_rf_rdata_b  (dbg_rf_rdata_b),
        .o_alu_op      (w_alu_op),
        .o_alu_b       (w_alu_b),
        .i_alu_result  (dbg_alu_result),
        .i_alu_done    (w_alu_done),
        .o_rf_wen      (dbg_rf_wen),
        .o_rf_waddr    (dbg_rf_waddr),
        .o_rf_wdata    (dbg_rf_wdata),
        .o_mem_req     (mem_req),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .i_mem_ack     (mem_ack),
        .o_illegal_op  (illegal_op)
    );

    regfile u_rf (
        .clk       (clk),
        .rst_n     (resetN),
        .i_raddr_a (dbg_rf_raddr_a),
        .i_raddr_b (dbg_rf_raddr_b),
        .o_rdata_a (dbg_rf_rdata_a),
        .o_rdata_b (dbg_rf_rdata_b),
        .i_wen     (dbg_rf_wen),
        .i_waddr   (dbg_rf_waddr),
        .i_wdata   (dbg_rf_wdata)
    );

    alu u_alu (
        .i_a      (dbg_rf_rdata_a),
        .i_b      (w_alu_b),
        .i_alu_op (w_alu_op),
        .o_result (dbg_alu_result),
        .o_done   (w_alu_done)
    );
endmodule

// File: tb/tb_core_top.sv
// tb/tb_core_top.sv - directed scoreboard bench for core_top
module tb_core_top;
    logic        clk = 1'b0;
    logic        resetN;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [7:0]  mem_core_id;
    logic        illegal_op;
    logic [31:0] dbg_alu_result, dbg_rf_rdata_a, dbg_rf_rdata_b, dbg_rf_wdata;
    logic [4:0]  dbg_rf_raddr_a, dbg_rf_raddr_b, dbg_rf_waddr;
    logic        dbg_rf_wen;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];

    core_top #(.CORE_INDEX(3), .INSTR_COUNT(4)) dut (
        .clk(clk), .resetN(resetN), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_core_id(mem_core_id), .illegal_op(illegal_op),
        .dbg_alu_result(dbg_alu_result), .dbg_rf_raddr_a(dbg_rf_raddr_a),
        .dbg_rf_raddr_b(dbg_rf_raddr_b), .dbg_rf_rdata_a(dbg_rf_rdata_a),
        .dbg_rf_rdata_b(dbg_rf_rdata_b), .dbg_rf_wen(dbg_rf_wen),
        .dbg_rf_waddr(dbg_rf_waddr), .dbg_rf_wdata(dbg_rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    // Issue one instruction, act as MIU, pop expected writes as dbg_rf_wen fires.
    task automatic run(input string tag, input logic [31:0] ins, input int exp_wen,
                       input int ack_delay, input logic [31:0] ack_data, input int exp_ill,
                       input logic exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        int  n_wen = 0, n_ill = 0, n_mem = 0, lat = 0, guard = 0;
        bit  done = 0;
        wr_t e;
        @(negedge clk);
        instr       = ins;
        instr_valid = 1'b1;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = $urandom;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                n_mem++;
                if (n_mem == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                end
            end
            @(negedge clk);
            lat++;
            if (mem_req) begin
                chk({tag, "_mem_we"}, 32'(mem_we), 32'(exp_we));
                chk({tag, "_mem_addr"}, mem_addr, exp_addr);
                if (exp_we) chk({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
            end
            if (dbg_rf_wen) begin
                n_wen++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk({tag, "_waddr"}, 32'(dbg_rf_waddr), 32'(e.rd));
                    chk({tag, "_wdata"}, dbg_rf_wdata, e.data);
                end
            end
            if (illegal_op) n_ill++;
            if (instr_ready) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        mem_ack = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'(3 + ack_delay));
        chk({tag, "_wen_cycles"}, 32'(n_wen), 32'(exp_wen));
        chk({tag, "_illegal"}, 32'(n_ill), 32'(exp_ill));
        chk({tag, "_mem_cycles"}, 32'(n_mem), 32'(ack_delay));
    endtask

    initial begin
        int guard;
        resetN      = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_illegal", 32'(illegal_op), 32'd0);
        chk("rst_rf_wen", 32'(dbg_rf_wen), 32'd0);
        chk("rst_raddr_a", 32'(dbg_rf_raddr_a), 32'd0);
        chk("rst_rdata_a", dbg_rf_rdata_a, 32'd0);
        chk("core_id", 32'(mem_core_id), 32'd3);
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);

        sb_q.push_back('{5'd1, 32'd5});
        run("addi_r1", enc(4'h8, 5'd1, 5'd0, 5'd0, 13'd5), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd2, 32'hFFFF_FFFD});
        run("addi_r2", enc(4'h8, 5'd2, 5'd0, 5'd0, 13'h1FFD), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd3, 32'd2});
        run("add_r3", enc(4'h1, 5'd3, 5'd1, 5'd2, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd4, 32'hFFFF_FFF8});
        run("sub_r4", enc(4'h2, 5'd4, 5'd2, 5'd1, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd5, 32'hFFFF_FFF8});
        run("xor_r5", enc(4'h5, 5'd5, 5'd1, 5'd2, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd0, 32'd7});
        run("addi_r0", enc(4'h8, 5'd0, 5'd0, 5'd0, 13'd7), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd6, 32'd0});
        run("add_r6", enc(4'h1, 5'd6, 5'd0, 5'd0, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        run("store", enc(4'hA, 5'd0, 5'd1, 5'd3, 13'd4), 0, 3, 32'h0, 0, 1'b1, 32'd9, 32'd2);
        sb_q.push_back('{5'd7, 32'hDEAD_BEEF});
        run("load", enc(4'h9, 5'd7, 5'd1, 5'd0, 13'd4), 1, 3, 32'hDEAD_BEEF, 0, 1'b0, 32'd9, 32'd0);
        sb_q.push_back('{5'd8, 32'd20});
        run("sll_r8", enc(4'h6, 5'd8, 5'd1, 5'd3, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd9, 32'h37AB_6FBB});
        run("srl_r9", enc(4'h7, 5'd9, 5'd7, 5'd3, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        run("illegal", enc(4'hF, 5'd10, 5'd1, 5'd2, 13'd0), 0, 0, 0, 1, 0, 0, 0);
        sb_q.push_back('{5'd11, 32'd0});
        run("read_r10", enc(4'h1, 5'd11, 5'd10, 5'd0, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        run("nop", enc(4'h0, 5'd12, 5'd1, 5'd2, 13'd1), 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a LOAD's MEM wait, with an ack coinciding and trailing.
        @(negedge clk);
        instr       = enc(4'h9, 5'd12, 5'd1, 5'd0, 13'd4);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        guard = 0;
        while (!mem_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("midmem_req", 32'(mem_req), 32'd1);
        resetN    = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        chk("midmem_req_drop", 32'(mem_req), 32'd0);
        chk("midmem_we_drop", 32'(mem_we), 32'd0);
        chk("midmem_rf_wen", 32'(dbg_rf_wen), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        chk("post_rst_wen", 32'(dbg_rf_wen), 32'd0);
        chk("post_rst_req", 32'(mem_req), 32'd0);
        sb_q.push_back('{5'd13, 32'd0});
        run("post_rst_r1r3", enc(4'h1, 5'd13, 5'd1, 5'd3, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        sb_q.push_back('{5'd14, 32'd0});
        run("post_rst_r7", enc(4'h4, 5'd14, 5'd7, 5'd9, 13'd0), 1, 0, 0, 0, 0, 0, 0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
